// File: rtl/aurora_pkg.sv
// Shared constants and state encoding for the
// Aurora 64B66B TX test-frame generator.
package aurora_pkg;

    localparam logic [7:0] HDR_MAGIC  = 8'hA5;
    localparam logic [7:0] KEEP_FULL  = 8'hFF;
    localparam logic [7:0] KEEP_UPPER = 8'hF0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/aurora_tx_test_framer_if.sv
// 64-bit AXI4-Stream TX bundle toward the MGT wrapper.
// master drives data/valid, slave returns ready.
interface aurora_tx_test_framer_if;

    logic [63:0] axiTXtdata;
    logic [7:0]  axiTXtkeep;
    logic        axiTXtvalid;
    logic        axiTXtlast;
    logic        axiTXtready;

    modport master (
        output axiTXtdata,
        output axiTXtkeep,
        output axiTXtvalid,
        output axiTXtlast,
        input  axiTXtready
    );

    modport slave (
        input  axiTXtdata,
        input  axiTXtkeep,
        input  axiTXtvalid,
        input  axiTXtlast,
        output axiTXtready
    );

endinterface

// File: rtl/aurora_frame_beat_gen.sv
// Combinational builder for one 64-bit beat of a test frame:
// header word 0, counter words 1..len, zero pad past the end.
module aurora_frame_beat_gen
    import aurora_pkg::*;
#(
    parameter int LEN_WIDTH = 8
) (
    input  logic [15:0]          seq,
    input  logic [LEN_WIDTH-1:0] len,
    input  logic [LEN_WIDTH-1:0] beat,
    output logic [63:0]          tdata,
    output logic [7:0]           tkeep,
    output logic                 tlast
);

    logic [LEN_WIDTH:0] wHi;
    logic [LEN_WIDTH:0] wLo;
    logic [LEN_WIDTH:0] lenX;

    assign wHi  = {beat, 1'b0};
    assign wLo  = {beat, 1'b1};
    assign lenX = {1'b0, len};

    // Upper word is always inside the frame; lower word may fall past it
    always_comb begin
        if (wHi == '0) begin
            tdata[63:32] = {HDR_MAGIC, 8'(len), seq};
        end else begin
            tdata[63:32] = {seq, 16'(wHi - 1'b1)};
        end
        if (wLo > lenX) begin
            tdata[31:0] = '0;
            tkeep       = KEEP_UPPER;
        end else begin
            tdata[31:0] = {seq, 16'(wLo - 1'b1)};
            tkeep       = KEEP_FULL;
        end
        tlast = (wLo >= lenX);
    end

endmodule

// File: rtl/aurora_tx_test_framer.sv
// Test-frame generator: FSM, beat/gap counters, frame counter
// and registered AXI4-Stream outputs on the MGT user clock.
module aurora_tx_test_framer
    import aurora_pkg::*;
#(
    parameter int LEN_WIDTH = 8,
    parameter int GAP_WIDTH = 8
) (
    input  logic                    auMGTclkOut,
    input  logic                    resetOut,
    input  logic                    enable,
    input  logic                    channelUp,
    input  logic [LEN_WIDTH-1:0]    frameLen,
    input  logic [GAP_WIDTH-1:0]    gapCycles,
    aurora_tx_test_framer_if.master axiTX,
    output logic [31:0]             frameCount,
    output logic                    busy
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_SEND = SEND;
    localparam logic [1:0] S_GAP  = GAP;

    logic [1:0]           state;
    logic [LEN_WIDTH-1:0] lenQ;
    logic [LEN_WIDTH-1:0] beatIdx;
    logic [GAP_WIDTH-1:0] gapCnt;
    logic [15:0]          seqQ;

    logic [15:0]          genSeq;
    logic [LEN_WIDTH-1:0] genLen;
    logic [LEN_WIDTH-1:0] genBeat;
    logic [63:0]          genData;
    logic [7:0]           genKeep;
    logic                 genLast;

    logic [63:0]          tdataQ;
    logic [7:0]           tkeepQ;
    logic                 tvalidQ;
    logic                 tlastQ;

    assign axiTX.axiTXtdata  = tdataQ;
    assign axiTX.axiTXtkeep  = tkeepQ;
    assign axiTX.axiTXtvalid = tvalidQ;
    assign axiTX.axiTXtlast  = tlastQ;

    // Idle: build the next header from live inputs; sending: the following beat
    always_comb begin
        genSeq  = seqQ;
        genLen  = lenQ;
        genBeat = beatIdx + 1'b1;
        if (state == S_IDLE) begin
            genSeq  = frameCount[15:0];
            genLen  = frameLen;
            genBeat = '0;
        end
    end

    aurora_frame_beat_gen #(
        .LEN_WIDTH (LEN_WIDTH)
    ) u_beatGen (
        .seq   (genSeq),
        .len   (genLen),
        .beat  (genBeat),
        .tdata (genData),
        .tkeep (genKeep),
        .tlast (genLast)
    );

    // Frame sequencing; a channel drop discards the frame in progress
    always_ff @(posedge auMGTclkOut or posedge resetOut) begin
        if (resetOut) begin
            state      <= S_IDLE;
            lenQ       <= '0;
            beatIdx    <= '0;
            gapCnt     <= '0;
            seqQ       <= '0;
            frameCount <= '0;
            busy       <= 1'b0;
            tdataQ     <= '0;
            tkeepQ     <= '0;
            tvalidQ    <= 1'b0;
            tlastQ     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (enable && channelUp) begin
                        state   <= S_SEND;
                        busy    <= 1'b1;
                        lenQ    <= frameLen;
                        gapCnt  <= gapCycles;
                        seqQ    <= frameCount[15:0];
                        beatIdx <= '0;
                        tdataQ  <= genData;
                        tkeepQ  <= genKeep;
                        tlastQ  <= genLast;
                        tvalidQ <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (!channelUp) begin
                        state   <= S_IDLE;
                        busy    <= 1'b0;
                        tvalidQ <= 1'b0;
                        tlastQ  <= 1'b0;
                        tkeepQ  <= '0;
                    end else if (tvalidQ && axiTX.axiTXtready) begin
                        if (tlastQ) begin
                            frameCount <= frameCount + 1'b1;
                            tvalidQ    <= 1'b0;
                            tlastQ     <= 1'b0;
                            tkeepQ     <= '0;
                            if (gapCnt != '0) begin
                                state <= S_GAP;
                            end else begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            beatIdx <= genBeat;
                            tdataQ  <= genData;
                            tkeepQ  <= genKeep;
                            tlastQ  <= genLast;
                        end
                    end
                end
                S_GAP: begin
                    gapCnt <= gapCnt - 1'b1;
                    if (!channelUp || gapCnt == GAP_WIDTH'(1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aurora_tx_test_framer.sv
// Scoreboard bench for aurora_tx_test_framer: frames are modelled
// as word lists, packed into expected beats and checked on accept.
module tb_aurora_tx_test_framer;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic        auMGTclkOut = 1'b0;
    logic        resetOut    = 1'b1;
    logic        enable      = 1'b0;
    logic        channelUp   = 1'b1;
    logic [7:0]  frameLen    = '0;
    logic [7:0]  gapCycles   = '0;
    logic [31:0] frameCount;
    logic        busy;

    aurora_tx_test_framer_if axiTX();

    aurora_tx_test_framer #(
        .LEN_WIDTH (8),
        .GAP_WIDTH (8)
    ) dut (
        .auMGTclkOut (auMGTclkOut),
        .resetOut    (resetOut),
        .enable      (enable),
        .channelUp   (channelUp),
        .frameLen    (frameLen),
        .gapCycles   (gapCycles),
        .axiTX       (axiTX),
        .frameCount  (frameCount),
        .busy        (busy)
    );

    always #5 auMGTclkOut = ~auMGTclkOut;

    beat_t       expQ[$];
    int          gapQ[$];
    int          passCnt    = 0;
    int          totalCnt   = 0;
    int          framesSeen = 0;
    int          beatsTotal = 0;
    bit          randReady  = 1'b0;
    logic [31:0] modelCount = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: header, then counter words, paired two per beat
    task automatic pushFrame(input int len, input logic [15:0] seq);
        logic [31:0] words[$];
        beat_t       b;
        words.push_back({8'hA5, 8'(len), seq});
        for (int k = 1; k <= len; k++) words.push_back({seq, 16'(k - 1)});
        for (int i = 0; i < words.size(); i += 2) begin
            b.data[63:32] = words[i];
            if (i + 1 < words.size()) begin
                b.data[31:0] = words[i + 1];
                b.keep       = 8'hFF;
            end else begin
                b.data[31:0] = '0;
                b.keep       = 8'hF0;
            end
            b.last = (i + 2 >= words.size());
            expQ.push_back(b);
        end
    endtask

    // Ready source: always ready or 50% random
    always @(posedge auMGTclkOut) begin
        #1;
        axiTX.axiTXtready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic [63:0] heldData;
    logic [8:0]  heldCtl;
    bit          stalled   = 1'b0;
    bit          afterLast = 1'b0;
    int          lowRun    = 0;

    // Monitor: hold-stability, accepted-beat compare, gap measurement
    always @(negedge auMGTclkOut) begin
        beat_t e;
        if (resetOut) begin
            stalled   = 1'b0;
            afterLast = 1'b0;
        end else if (axiTX.axiTXtvalid) begin
            if (afterLast) begin
                gapQ.push_back(lowRun);
                afterLast = 1'b0;
            end
            if (stalled) begin
                chk("hold_data", axiTX.axiTXtdata, heldData);
                chk("hold_ctl", 64'({axiTX.axiTXtkeep, axiTX.axiTXtlast}),
                    64'(heldCtl));
            end
            if (axiTX.axiTXtready === 1'b1) begin
                stalled = 1'b0;
                if (expQ.size() == 0) begin
                    totalCnt++;
                    $display("FAIL extra_beat: got %h expected no beat",
                             axiTX.axiTXtdata);
                end else begin
                    e = expQ.pop_front();
                    chk("beat_data", axiTX.axiTXtdata, e.data);
                    chk("beat_keep_last",
                        64'({axiTX.axiTXtkeep, axiTX.axiTXtlast}),
                        64'({e.keep, e.last}));
                end
                beatsTotal++;
                if (axiTX.axiTXtlast) begin
                    framesSeen++;
                    afterLast = 1'b1;
                    lowRun    = 0;
                end
            end else begin
                stalled  = 1'b1;
                heldData = axiTX.axiTXtdata;
                heldCtl  = {axiTX.axiTXtkeep, axiTX.axiTXtlast};
            end
        end else begin
            stalled = 1'b0;
            if (afterLast) lowRun++;
        end
    end

    task automatic waitIdle();
        int guard = 0;
        while (busy && guard < 600) begin
            @(posedge auMGTclkOut); #1;
            guard++;
        end
        chk("idle_wait", 64'(busy), 64'd0);
    endtask

    task automatic waitFrames(input int target);
        int guard = 0;
        while (framesSeen < target && guard < 3000) begin
            @(posedge auMGTclkOut); #1;
            guard++;
        end
        chk("frame_done", 64'(framesSeen), 64'(target));
    endtask

    // Pulse enable from idle; header must be valid one edge later
    task automatic startFrame(input int len, input int gap);
        waitIdle();
        pushFrame(len, modelCount[15:0]);
        frameLen  = 8'(len);
        gapCycles = 8'(gap);
        enable    = 1'b1;
        @(posedge auMGTclkOut); #1;
        chk("start_latency", 64'(axiTX.axiTXtvalid), 64'd1);
        enable    = 1'b0;
        frameLen  = 8'($urandom);
        gapCycles = 8'($urandom);
    endtask

    task automatic oneFrame(input int len, input int gap);
        int target;
        target = framesSeen + 1;
        startFrame(len, gap);
        waitFrames(target);
        modelCount = modelCount + 1;
        chk("frame_count", 64'(frameCount), 64'(modelCount));
        chk("queue_drained", 64'(expQ.size()), 64'd0);
    endtask

    initial begin
        int          base;
        int          len;
        logic [31:0] cntBefore;

        axiTX.axiTXtready = 1'b1;
        repeat (3) @(posedge auMGTclkOut);
        #1;
        chk("rst_valid", 64'(axiTX.axiTXtvalid), 64'd0);
        chk("rst_last", 64'(axiTX.axiTXtlast), 64'd0);
        chk("rst_keep", 64'(axiTX.axiTXtkeep), 64'd0);
        chk("rst_data", axiTX.axiTXtdata, 64'd0);
        chk("rst_count", 64'(frameCount), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        resetOut = 1'b0;
        @(posedge auMGTclkOut); #1;

        oneFrame(3, 0);
        oneFrame(0, 0);
        oneFrame(4, 0);
        oneFrame(1, 2);

        randReady = 1'b1;
        oneFrame(20, 0);
        randReady = 1'b0;

        // Back-to-back frames with enable held and a 5-cycle gap
        waitIdle();
        base = framesSeen;
        len  = $urandom_range(1, 6);
        for (int i = 0; i < 3; i++) pushFrame(len, 16'(modelCount[15:0] + 16'(i)));
        frameLen  = 8'(len);
        gapCycles = 8'd5;
        enable    = 1'b1;
        waitFrames(base + 1);
        gapQ.delete();
        waitFrames(base + 3);
        enable     = 1'b0;
        modelCount = modelCount + 3;
        chk("gap_count", 64'(frameCount), 64'(modelCount));
        chk("gap_entries", 64'(gapQ.size()), 64'd2);
        foreach (gapQ[i]) chk("gap_len", 64'(gapQ[i]), 64'd6);

        for (int i = 0; i < 6; i++) begin
            randReady = 1'($urandom_range(0, 1));
            oneFrame($urandom_range(0, 40), $urandom_range(0, 3));
        end
        randReady = 1'b0;

        // Channel drop while beat 2 of an L=10 frame is presented
        waitIdle();
        base      = beatsTotal;
        cntBefore = frameCount;
        startFrame(10, 0);
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        void'(expQ.pop_back());
        for (int g = 0; g < 100 && beatsTotal < base + 2; g++) begin
            @(posedge auMGTclkOut); #2;
        end
        chk("drop_reach", 64'(beatsTotal), 64'(base + 2));
        channelUp = 1'b0;
        @(posedge auMGTclkOut); #1;
        chk("drop_valid", 64'(axiTX.axiTXtvalid), 64'd0);
        chk("drop_ctl", 64'({axiTX.axiTXtkeep, axiTX.axiTXtlast}), 64'd0);
        chk("drop_busy", 64'(busy), 64'd0);
        chk("drop_count", 64'(frameCount), 64'(cntBefore));
        chk("drop_queue", 64'(expQ.size()), 64'd0);
        channelUp = 1'b1;
        @(posedge auMGTclkOut); #1;
        oneFrame(10, 0);

        // Counter wrap: seq FFFF frame, then seq 0000 frame
        waitIdle();
        force dut.frameCount = 32'hFFFF_FFFF;
        @(posedge auMGTclkOut); #1;
        release dut.frameCount;
        modelCount = 32'hFFFF_FFFF;
        oneFrame(2, 0);
        oneFrame(1, 0);

        // Asynchronous reset in the middle of a long frame
        waitIdle();
        pushFrame(30, modelCount[15:0]);
        frameLen = 8'd30;
        enable   = 1'b1;
        repeat (5) @(posedge auMGTclkOut);
        #3;
        resetOut = 1'b1;
        #1;
        chk("arst_valid", 64'(axiTX.axiTXtvalid), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_count", 64'(frameCount), 64'd0);
        enable = 1'b0;
        expQ.delete();
        modelCount = '0;
        @(posedge auMGTclkOut); #1;
        resetOut = 1'b0;
        @(posedge auMGTclkOut); #1;
        oneFrame(6, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/aurora_tx_test_framer.md
# aurora_tx_test_framer

Test-frame generator on the 64-bit Aurora 64B66B transmit side. It produces numbered, self-describing frames on the 64-bit AXI4-Stream TX input of the MGT wrapper. It runs in the auMGTclkOut domain and bypasses the 32→64 upconverter. The far end, or a local loopback, can verify sequence, length and payload through the RX downconverter path and the CRC tuser bits.

## Interface
Parameters:
- LEN_WIDTH, 8, width of frameLen; payload length in 32-bit words (0..2^LEN_WIDTH-1)
- GAP_WIDTH, 8, width of gapCycles

Ports:
- auMGTclkOut  in  1  MGT user clock; all logic is on this clock
- resetOut  in  1  reset, asynchronous, active-high; clock auMGTclkOut
- enable  in  1  run request; already synchronous to auMGTclkOut
- channelUp  in  1  mgtChannelUP from the MGT wrapper
- frameLen  in  LEN_WIDTH  payload words per frame; sampled at frame start
- gapCycles  in  GAP_WIDTH  extra idle cycles after each frame; sampled at frame start
- axiTXtdata  out  64  TX data; first 32-bit word in [63:32]
- axiTXtkeep  out  8  byte enables; tkeep[7] qualifies tdata[63:56]
- axiTXtvalid  out  1  TX valid
- axiTXtlast  out  1  last beat of frame
- axiTXtready  in  1  TX ready from the MGT wrapper
- frameCount  out  32  completed frames since reset; wraps
- busy  out  1  high while state ≠ IDLE

## Operation
- States: IDLE, SEND, GAP.
- IDLE → SEND when enable && channelUp:
  - latch L = frameLen and G = gapCycles;
  - seq = frameCount[15:0];
  - total words N = L+1; beats B = ceil(N/2).
- Word 0, the header, = {8'hA5, L zero-extended/truncated to 8 bits, seq}.
- Word k for k = 1..L = {seq, (k-1)[15:0]}.
- Beat j carries word 2j in [63:32] and word 2j+1 in [31:0].
- tkeep is 8'hFF except on the final beat when N is odd. That beat has tkeep 8'hF0 with [31:0] = 0.
- tlast is high only on beat B-1.
- L=0 produces a header-only frame: 1 beat, tkeep 8'hF0, tlast=1.
- SEND: the beat advances on axiTXtvalid && axiTXtready. When the last beat is accepted:
  - frameCount increments;
  - go to GAP if G>0, else go to IDLE.
- GAP: counts G cycles, then goes to IDLE.
- Dropping enable mid-frame does not abort; the frame completes, then the block stays in IDLE.
- channelUp low in SEND or GAP:
  - next cycle valid=0, tlast=0, tkeep=0 and state = IDLE;
  - frameCount is not incremented and the partial frame is discarded. This is the only permitted valid withdrawal.
- frameLen and gapCycles changes mid-frame have no effect until the next frame start.

## Timing
- All outputs are registered.
- Reset values: axiTXtvalid 0, axiTXtlast 0, axiTXtkeep 8'h00, axiTXtdata 0, frameCount 0, busy 0, state IDLE.
- Start latency: if enable && channelUp is sampled high in IDLE at edge t, the header beat is valid from edge t+1.
- While valid && !ready, tdata, tkeep and tlast hold stable.
- With continuous ready, a frame occupies exactly B consecutive valid cycles.
- Inter-frame gap with enable held: valid is low for exactly G+1 cycles (GAP G cycles + IDLE 1 cycle).
- frameCount updates on the edge after last-beat acceptance. The next header uses the updated value.
- frameCount wraps 32'hFFFFFFFF → 0. Frames with seq = 16'hFFFF are followed by frames with seq = 0.
- Reset assertion mid-frame clears everything asynchronously. Deassertion is already synchronised upstream.

## Structure
- Shared package aurora_pkg:
  - header magic 8'hA5;
  - KEEP_FULL 8'hFF and KEEP_UPPER 8'hF0;
  - state enum {IDLE, SEND, GAP}.
- Sub-module aurora_frame_beat_gen: combinational beat builder. Inputs are seq, L and beat index j; outputs are tdata, tkeep and tlast.
- The top module holds the FSM, beat counter, gap counter, frameCount and output registers.

## Test plan
- L=3, G=0, ready=1 → 2 beats:
  - beat 0: {A5030000, 00000000}, keep FF;
  - beat 1: {00000001, 00000002}, keep FF, last;
  - frameCount → 1.
- L=0 → 1 beat: tdata {A5000000, 00000000}, keep F0, last. L=4 → 3 beats, final beat keep F0 with low half 0.
- Random ready backpressure at 50% while sending L=20 → every beat is held stable while stalled; 11 beats are accepted in order.
- G=5 with enable held → exactly 6 cycles of valid=0 between tlast acceptance and the next header. Header seq increments each frame.
- channelUp dropped on beat 2 of L=10 → valid low the next cycle, frameCount unchanged; the next frame reuses the same seq.
- Preload frameCount to 32'hFFFFFFFF by forcing, then send one frame → frameCount 0; the header of the following frame carries seq 0000.
